delaychain_meter: RTL and testbench
===================================

// Module: delaychain_meter
// PURPOSE
//   Stimulus/measurement end of the delay-chain test structure. Drives a launch edge
//   into every chain lane and timestamps, per lane, the clock edge at which that edge
//   comes back on the chain output. Software reads the per-lane cycle counts.
//   Sits beside the chain in the same clock domain. launch feeds the chain din bits;
//   the chain dout bits return on echo.
// PARAMETERS
//   WIDTH    8     number of lanes (launch/echo bits)
//   CNT_W    12    timestamp/counter width
//   TIMEOUT  4095  max cycles in SETTLE or MEASURE before abandoning; must be < 2**CNT_W
// PORTS
//   clk        in   1               clock
//   rst        in   1               asynchronous, active-high reset
//   start      in   1               1-cycle request to run one measurement
//   abort      in   1               synchronous abort to IDLE
//   lane_mask  in   WIDTH           lanes that must arrive; sampled on accepted start
//   echo       in   WIDTH           chain outputs, synchronous to clk, sampled directly
//   launch     out  WIDTH           chain inputs; all bits always equal the launch level
//   busy       out  1               high in SETTLE or MEASURE
//   done       out  1               1-cycle pulse on entering DONE
//   timeout    out  1               last run hit TIMEOUT (sticky until next accepted start)
//   settle_err out  1               last run timed out in SETTLE (sticky, as timeout)
//   arrived    out  WIDTH           per-lane: edge returned in last run
//   rd_sel     in   $clog2(WIDTH)   lane select for readout
//   rd_stamp   out  CNT_W           stamp of lane rd_sel (combinational mux)
// BEHAVIOUR
//   Reset: state=IDLE, level=0, launch=0, cnt=0, busy=0, done=0, timeout=0,
//     settle_err=0, arrived=0, all stamps=0.
//   FSM IDLE -> SETTLE -> MEASURE -> DONE -> IDLE.
//   IDLE: start=1 accepted. Latch mask, clear arrived/stamps/timeout/settle_err,
//     cnt<=0, go SETTLE. start outside IDLE is ignored (no queueing).
//   SETTLE: launch holds level L. Each cycle, if (echo^{WIDTH{L}})&mask==0, then
//     cnt<=0, launch<=~L, go MEASURE. Call this edge E0.
//     Else cnt++. If cnt==TIMEOUT, set settle_err and timeout, then go DONE.
//   MEASURE: cnt increments on every edge after E0, so cnt=k-1 before edge Ek.
//     At edge Ek, lane i with mask[i]=1, arrived[i]=0 and echo[i]==~L sets
//     arrived[i]<=1 and stamp[i]<=k (= cnt+1).
//     Only the first arrival is recorded; later echo toggles are ignored.
//     Unmasked lanes never arrive and keep stamp 0.
//     When all masked lanes are arrived (including those that arrive this edge),
//       go DONE.
//     Else if cnt+1==TIMEOUT, set timeout and go DONE. Lanes that have not arrived
//       keep stamp=0 and arrived=0. An arrival on the timeout edge is still recorded.
//   DONE: done=1 for exactly one cycle. level<=~L, so the next run launches the
//     opposite edge. Go IDLE. Launch stays at the new level (no return to L).
//   lane_mask==0 at start: SETTLE passes immediately. The next edge enters DONE
//     with no arrivals; the launch level still toggles.
//   abort (any state, priority over start): go IDLE next edge. Launch is held at its
//     current value; level<=launch value. arrived/stamps/flags are cleared. No done.
//   Async rst mid-run: immediate return to reset values; launch drops to 0.
//   Timing reference: echo wired directly to launch gives stamp 1. N flops in
//     the echo path give stamp N+1.
//   Counter never wraps: TIMEOUT < 2**CNT_W guarantees cnt+1 fits.
// TESTING
//   T1 loopback: echo=launch, mask=FF, start -> SETTLE 1 cycle, all arrived=FF,
//      every stamp=1, done pulse, timeout=0, launch goes 00->FF.
//   T2 lane skew: lane i delayed by 3*i flops, second run (falling edge) ->
//      stamps 1,4,7,...,22; launch FF->00.
//   T3 timeout: TIMEOUT=100, lane 5 echo tied to 0, mask=FF, rising run ->
//      timeout=1, arrived=DF, stamp[5]=0, done 100 cycles after E0.
//   T4 settle error: echo stuck at opposite of L on lane 0 -> settle_err=1,
//      timeout=1, launch unchanged, arrived=00.
//   T5 abort/reset: abort at MEASURE cycle 2 -> IDLE, no done, arrived=00.
//      Repeat with rst pulse -> launch=0 asynchronously. Next start works normally.
//   T6 start while busy and mask=00: extra starts ignored. Mask 00 -> done 2 cycles
//      after start, arrived=00.

Source files
------------

// File: rtl/delaychain_meter.sv
// Launches an edge into every delay-chain lane and timestamps each lane's returning edge.
// Latency: stamp k means the echo was seen k clock edges after the launch edge (loopback = 1).
// Backpressure: none; start is accepted only in IDLE and ignored otherwise (no queueing).
module delaychain_meter #(
    parameter int WIDTH   = 8,
    parameter int CNT_W   = 12,
    parameter int TIMEOUT = 4095
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     abort,
    input  logic [WIDTH-1:0]         lane_mask,
    input  logic [WIDTH-1:0]         echo,
    output logic [WIDTH-1:0]         launch,
    output logic                     busy,
    output logic                     done,
    output logic                     timeout,
    output logic                     settle_err,
    output logic [WIDTH-1:0]         arrived,
    input  logic [$clog2(WIDTH)-1:0] rd_sel,
    output logic [CNT_W-1:0]         rd_stamp
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETTLE  = 2'd1,
        MEASURE = 2'd2,
        DONE    = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

    state_t           state;
    state_t           next_state;
    logic             level;
    logic [WIDTH-1:0] mask;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] stamp [WIDTH];

    logic [WIDTH-1:0] lvl_vec;
    logic [WIDTH-1:0] diff;
    logic [WIDTH-1:0] hit;
    logic [CNT_W-1:0] cnt_inc;
    logic             settled;
    logic             all_arr;
    logic             settle_to;
    logic             meas_to;

    // Lane comparison terms: a lane differs from the launched level once its edge returns.
    always_comb begin
        lvl_vec   = {WIDTH{level}};
        diff      = echo ^ lvl_vec;
        settled   = ((diff & mask) == '0);
        hit       = mask & ~arrived & diff;
        all_arr   = (((arrived | hit) & mask) == mask);
        cnt_inc   = cnt + CNT_W'(1);
        settle_to = (cnt == TIMEOUT_C);
        meas_to   = (cnt_inc == TIMEOUT_C);
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; abort overrides everything, including a coincident start.
    always_comb begin
        next_state = state;
        if (abort) begin
            next_state = IDLE;
        end else begin
            case (state)
                IDLE:    if (start) next_state = SETTLE;
                SETTLE:  if (settled || settle_to) next_state = (settled ? MEASURE : DONE);
                MEASURE: if (all_arr || meas_to) next_state = DONE;
                DONE:    next_state = IDLE;
                default: next_state = IDLE;
            endcase
        end
    end

    // Datapath: launch level, counter, per-lane arrival flags and stamps, sticky flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level      <= 1'b0;
            launch     <= '0;
            mask       <= '0;
            cnt        <= '0;
            timeout    <= 1'b0;
            settle_err <= 1'b0;
            arrived    <= '0;
            for (int i = 0; i < WIDTH; i++) stamp[i] <= '0;
        end else if (abort) begin
            // Launch holds where it is; the next run starts from that level.
            level      <= launch[0];
            cnt        <= '0;
            timeout    <= 1'b0;
            settle_err <= 1'b0;
            arrived    <= '0;
            for (int i = 0; i < WIDTH; i++) stamp[i] <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        mask       <= lane_mask;
                        launch     <= lvl_vec;
                        cnt        <= '0;
                        timeout    <= 1'b0;
                        settle_err <= 1'b0;
                        arrived    <= '0;
                        for (int i = 0; i < WIDTH; i++) stamp[i] <= '0;
                    end
                end
                SETTLE: begin
                    if (settled) begin
                        cnt    <= '0;
                        launch <= ~lvl_vec;
                    end else if (settle_to) begin
                        settle_err <= 1'b1;
                        timeout    <= 1'b1;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                MEASURE: begin
                    arrived <= arrived | hit;
                    for (int i = 0; i < WIDTH; i++) begin
                        if (hit[i]) stamp[i] <= cnt_inc;
                    end
                    if (!all_arr) begin
                        if (meas_to) timeout <= 1'b1;
                        else         cnt     <= cnt_inc;
                    end
                end
                DONE: begin
                    level <= ~level;
                end
                default: ;
            endcase
        end
    end

    // Status decode and readout mux.
    always_comb begin
        busy     = (state == SETTLE) || (state == MEASURE);
        done     = (state == DONE);
        rd_stamp = stamp[rd_sel];
    end

endmodule

// File: tb/tb_delaychain_meter.sv
// Directed bench for delaychain_meter: loopback, lane skew, timeouts, abort/reset, busy starts.
// Echo is modelled as a per-lane programmable flop delay of launch, with optional stuck lanes.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_delaychain_meter;

    localparam int WIDTH   = 8;
    localparam int CNT_W   = 12;
    localparam int TIMEOUT = 100;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             abort;
    logic [WIDTH-1:0] lane_mask;
    logic [WIDTH-1:0] echo;
    logic [WIDTH-1:0] launch;
    logic             busy;
    logic             done;
    logic             timeout;
    logic             settle_err;
    logic [WIDTH-1:0] arrived;
    logic [2:0]       rd_sel;
    logic [CNT_W-1:0] rd_stamp;

    int               vectors = 0;
    int               miscompares = 0;

    int               dly [WIDTH];
    logic [WIDTH-1:0] stuck_en;
    logic [WIDTH-1:0] stuck_val;
    logic [31:0]      pipe [WIDTH];

    delaychain_meter #(.WIDTH(WIDTH), .CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .lane_mask(lane_mask),
        .echo(echo), .launch(launch), .busy(busy), .done(done), .timeout(timeout),
        .settle_err(settle_err), .arrived(arrived), .rd_sel(rd_sel), .rd_stamp(rd_stamp)
    );

    always #5 clk = ~clk;

    // Chain model: per-lane shift register of launch.
    always @(posedge clk) begin
        for (int i = 0; i < WIDTH; i++) pipe[i] <= {pipe[i][30:0], launch[i]};
    end

    always_comb begin
        echo = '0;
        for (int i = 0; i < WIDTH; i++) begin
            echo[i] = (dly[i] == 0) ? launch[i] : pipe[i][dly[i]-1];
            if (stuck_en[i]) echo[i] = stuck_val[i];
        end
    end

    task automatic pulse_start(input logic [WIDTH-1:0] m);
        @(negedge clk);
        lane_mask = m;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int n);
        n = -1;
        for (int k = 1; k <= budget; k++) begin
            @(negedge clk);
            if (done) begin
                n = k;
                break;
            end
        end
    endtask

    task automatic idle_cycles(input int n);
        for (int k = 0; k < n; k++) @(negedge clk);
    endtask

    task automatic test_reset;
        @(negedge clk);
        vectors++;
        if ({launch, busy, done, timeout, settle_err, arrived} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: launch=%h busy=%b done=%b to=%b se=%b arr=%h, required all 0",
                     launch, busy, done, timeout, settle_err, arrived);
        end
        rst = 1'b0;
        @(negedge clk);
        for (int i = 0; i < WIDTH; i++) begin
            rd_sel = 3'(i);
            #1;
            vectors++;
            if (rd_stamp !== 12'd0) begin
                miscompares++;
                $display("FAIL reset_stamp[%0d]: got %0d, required 0", i, rd_stamp);
            end
        end
    endtask

    task automatic test_loopback;
        int n;
        pulse_start(8'hFF);
        vectors++;
        if (busy !== 1'b1 || launch !== 8'h00) begin
            miscompares++;
            $display("FAIL loop_settle: busy=%b launch=%h, required busy=1 launch=00", busy, launch);
        end
        wait_done(20, n);
        vectors++;
        if (n !== 2) begin
            miscompares++;
            $display("FAIL loop_done_cycle: got %0d, required 2", n);
        end
        vectors++;
        if (arrived !== 8'hFF || timeout !== 1'b0 || launch !== 8'hFF) begin
            miscompares++;
            $display("FAIL loop_flags: arr=%h to=%b launch=%h, required FF 0 FF", arrived, timeout, launch);
        end
        @(negedge clk);
        vectors++;
        if (done !== 1'b0) begin
            miscompares++;
            $display("FAIL loop_done_pulse: done=%b one cycle later, required 0", done);
        end
        for (int i = 0; i < WIDTH; i++) begin
            rd_sel = 3'(i);
            #1;
            vectors++;
            if (rd_stamp !== 12'd1) begin
                miscompares++;
                $display("FAIL loop_stamp[%0d]: got %0d, required 1", i, rd_stamp);
            end
        end
    endtask

    task automatic test_lane_skew;
        int n;
        for (int i = 0; i < WIDTH; i++) dly[i] = 3 * i;
        idle_cycles(30);
        pulse_start(8'hFF);
        wait_done(60, n);
        vectors++;
        if (n !== 23) begin
            miscompares++;
            $display("FAIL skew_done_cycle: got %0d, required 23", n);
        end
        vectors++;
        if (arrived !== 8'hFF || launch !== 8'h00 || timeout !== 1'b0) begin
            miscompares++;
            $display("FAIL skew_flags: arr=%h launch=%h to=%b, required FF 00 0", arrived, launch, timeout);
        end
        for (int i = 0; i < WIDTH; i++) begin
            rd_sel = 3'(i);
            #1;
            vectors++;
            if (rd_stamp !== 12'(3 * i + 1)) begin
                miscompares++;
                $display("FAIL skew_stamp[%0d]: got %0d, required %0d", i, rd_stamp, 3 * i + 1);
            end
        end
    endtask

    task automatic test_timeout;
        int n;
        int k0;
        for (int i = 0; i < WIDTH; i++) dly[i] = 0;
        stuck_en = 8'h20;
        stuck_val = 8'h00;
        idle_cycles(3);
        pulse_start(8'hFF);
        k0 = -1;
        for (int k = 0; k < 20; k++) begin
            if (launch === 8'hFF) begin
                k0 = k;
                break;
            end
            @(negedge clk);
        end
        vectors++;
        if (k0 < 0) begin
            miscompares++;
            $display("FAIL to_launch_edge: launch=%h, required FF within 20 cycles", launch);
        end
        wait_done(200, n);
        vectors++;
        if (n !== TIMEOUT) begin
            miscompares++;
            $display("FAIL to_done_cycle: got %0d after E0, required %0d", n, TIMEOUT);
        end
        vectors++;
        if (timeout !== 1'b1 || settle_err !== 1'b0 || arrived !== 8'hDF) begin
            miscompares++;
            $display("FAIL to_flags: to=%b se=%b arr=%h, required 1 0 DF", timeout, settle_err, arrived);
        end
        rd_sel = 3'd5;
        #1;
        vectors++;
        if (rd_stamp !== 12'd0) begin
            miscompares++;
            $display("FAIL to_stamp5: got %0d, required 0", rd_stamp);
        end
        rd_sel = 3'd4;
        #1;
        vectors++;
        if (rd_stamp !== 12'd1) begin
            miscompares++;
            $display("FAIL to_stamp4: got %0d, required 1", rd_stamp);
        end
        stuck_en = 8'h00;
    endtask

    task automatic test_settle_err;
        int n;
        idle_cycles(3);
        stuck_en = 8'h01;
        stuck_val = 8'h00;
        pulse_start(8'hFF);
        wait_done(300, n);
        vectors++;
        if (n < 0) begin
            miscompares++;
            $display("FAIL se_done: no done within 300 cycles, required a done");
        end
        vectors++;
        if (settle_err !== 1'b1 || timeout !== 1'b1 || launch !== 8'hFF || arrived !== 8'h00) begin
            miscompares++;
            $display("FAIL se_flags: se=%b to=%b launch=%h arr=%h, required 1 1 FF 00",
                     settle_err, timeout, launch, arrived);
        end
        stuck_en = 8'h00;
    endtask

    task automatic test_abort_reset;
        int n;
        int seen_done;
        for (int i = 0; i < WIDTH; i++) dly[i] = 10;
        idle_cycles(3);
        pulse_start(8'hFF);
        n = -1;
        for (int k = 0; k < 60; k++) begin
            if (launch === 8'hFF) begin
                n = k;
                break;
            end
            @(negedge clk);
        end
        vectors++;
        if (n < 0 || settle_err !== 1'b0 || timeout !== 1'b0) begin
            miscompares++;
            $display("FAIL ab_launch: launch=%h se=%b to=%b, required FF 0 0", launch, settle_err, timeout);
        end
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        vectors++;
        if (busy !== 1'b0 || arrived !== 8'h00 || launch !== 8'hFF) begin
            miscompares++;
            $display("FAIL ab_state: busy=%b arr=%h launch=%h, required 0 00 FF", busy, arrived, launch);
        end
        seen_done = 0;
        for (int k = 0; k < 30; k++) begin
            if (done) seen_done++;
            @(negedge clk);
        end
        vectors++;
        if (seen_done !== 0) begin
            miscompares++;
            $display("FAIL ab_no_done: %0d done cycles, required 0", seen_done);
        end
        pulse_start(8'hFF);
        idle_cycles(3);
        rst = 1'b1;
        #1;
        vectors++;
        if (launch !== 8'h00 || busy !== 1'b0 || done !== 1'b0 || arrived !== 8'h00) begin
            miscompares++;
            $display("FAIL rst_async: launch=%h busy=%b done=%b arr=%h, required 00 0 0 00",
                     launch, busy, done, arrived);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < WIDTH; i++) dly[i] = 0;
        idle_cycles(2);
        pulse_start(8'hFF);
        wait_done(20, n);
        vectors++;
        if (n !== 2 || arrived !== 8'hFF || launch !== 8'hFF || timeout !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_rerun: n=%0d arr=%h launch=%h to=%b, required 2 FF FF 0",
                     n, arrived, launch, timeout);
        end
    endtask

    task automatic test_back_to_back;
        int ndone;
        int first;
        idle_cycles(3);
        @(negedge clk);
        lane_mask = 8'h00;
        start = 1'b1;
        ndone = 0;
        first = -1;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (k == 3) start = 1'b0;
            if (done) begin
                ndone++;
                if (first < 0) first = k;
            end
        end
        vectors++;
        if (ndone !== 1 || first !== 3) begin
            miscompares++;
            $display("FAIL b2b_done: count=%0d first=%0d, required 1 at 3", ndone, first);
        end
        vectors++;
        if (arrived !== 8'h00 || launch !== 8'h00 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_flags: arr=%h launch=%h busy=%b, required 00 00 0", arrived, launch, busy);
        end
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        lane_mask = '0;
        rd_sel = '0;
        stuck_en = '0;
        stuck_val = '0;
        for (int i = 0; i < WIDTH; i++) dly[i] = 0;
        test_reset;
        test_loopback;
        test_lane_skew;
        test_timeout;
        test_settle_err;
        test_abort_reset;
        test_back_to_back;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
